// File: rtl/host_ingress.sv
// Avalon-MM host-to-fabric ingress: three word FIFOs drained into switch ports data1..data3.
// Optional build macro INGRESS_ZERO_SKIP_EN discards popped all-zero words instead of emitting them.
module host_ingress #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        rdy1,
  input  logic        rdy2,
  input  logic        rdy3,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] data3,
  output logic        en1,
  output logic        en2,
  output logic        en3
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           mem [3][DEPTH];
  logic [2:0][AW-1:0]    wr_ptr;
  logic [2:0][AW-1:0]    rd_ptr;
  logic [2:0][LW-1:0]    count;
  logic [2:0][CW-1:0]    sent;
  logic [2:0]            ovf;
  logic [2:0][31:0]      data_q;
  logic [2:0]            en_q;

  logic [2:0]            rdy_v;
  logic [2:0]            push;
  logic [2:0]            accept;
  logic [2:0]            pop;
  logic [2:0]            emit;
  logic [2:0]            full;
  logic [2:0]            empty;
  logic [2:0][31:0]      head;

  logic wr_ok;
  logic ctrl_wr;

  assign rdy_v   = {rdy3, rdy2, rdy1};
  assign wr_ok   = chipselect && write && !read && (byteenable == 4'hF);
  assign ctrl_wr = wr_ok && (address == 4'd4);

  // Flush wins over start/stop; a flush lasts one cycle and always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl_wr && writedata[1])      state_nxt = FLUSH;
        else if (ctrl_wr && writedata[0]) state_nxt = RUN;
      end
      RUN: begin
        if (ctrl_wr && writedata[1])      state_nxt = FLUSH;
        else if (ctrl_wr && writedata[2]) state_nxt = IDLE;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push   = '0;
    accept = '0;
    pop    = '0;
    emit   = '0;
    full   = '0;
    empty  = '0;
    head   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      full[i]   = (count[i] == LW'(DEPTH));
      empty[i]  = (count[i] == '0);
      head[i]   = mem[i][rd_ptr[i]];
      push[i]   = wr_ok && (address == 4'(i + 1)) && (state != FLUSH);
      accept[i] = push[i] && !full[i];
      pop[i]    = (state == RUN) && !empty[i] && rdy_v[i];
`ifdef INGRESS_ZERO_SKIP_EN
      emit[i]   = pop[i] && (head[i] != '0);
`else
      emit[i]   = pop[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sent     <= '0;
      ovf      <= '0;
      data_q   <= '0;
      en_q     <= '0;
      readdata <= '0;
    end else begin
      state <= state_nxt;
      for (int unsigned i = 0; i < 3; i++) begin
        if (state == FLUSH) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
          sent[i]   <= '0;
          ovf[i]    <= 1'b0;
          en_q[i]   <= 1'b0;
        end else begin
          en_q[i] <= emit[i];
          if (emit[i])   data_q[i] <= head[i];
          if (pop[i])    rd_ptr[i] <= rd_ptr[i] + 1'b1;
          if (accept[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          // Fullness is taken from the start of the cycle, so a pop never rescues a push.
          if (push[i] && full[i]) ovf[i] <= 1'b1;
          if (emit[i])   sent[i] <= sent[i] + 1'b1;
          case ({accept[i], pop[i]})
            2'b10:   count[i] <= count[i] + 1'b1;
            2'b01:   count[i] <= count[i] - 1'b1;
            default: count[i] <= count[i];
          endcase
        end
      end

      if (chipselect && read) begin
        case (address)
          4'd8:    readdata <= 32'(count[0]);
          4'd9:    readdata <= 32'(count[1]);
          4'd10:   readdata <= 32'(count[2]);
          4'd11:   readdata <= 32'(sent[0]);
          4'd12:   readdata <= 32'(sent[1]);
          4'd13:   readdata <= 32'(sent[2]);
          4'd14:   readdata <= {25'd0, ovf, 2'b00, state};
          default: readdata <= 32'd252;
        endcase
      end else begin
        readdata <= 32'd251;
      end
    end
  end

  assign data1 = data_q[0];
  assign data2 = data_q[1];
  assign data3 = data_q[2];
  assign en1   = en_q[0];
  assign en2   = en_q[1];
  assign en3   = en_q[2];

endmodule

// File: tb/tb_host_ingress.sv
// Self-checking bench for host_ingress: register-read table, scoreboarded port emission, corner sequences.
module tb_host_ingress;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 12;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        rdy1, rdy2, rdy3;
  logic [31:0] data1, data2, data3;
  logic        en1, en2, en3;

  int checks = 0;
  int errors = 0;
  int pulses [3];

  logic [31:0] sb1 [$];
  logic [31:0] sb2 [$];
  logic [31:0] sb3 [$];

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [12];

  host_ingress #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chipselect(chipselect),
    .read      (read),
    .write     (write),
    .byteenable(byteenable),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .rdy1      (rdy1),
    .rdy2      (rdy2),
    .rdy3      (rdy3),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .en1       (en1),
    .en2       (en2),
    .en3       (en3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int n, output logic ok, output logic [31:0] w);
    ok = 1'b0;
    w  = '0;
    case (n)
      0: if (sb1.size() > 0) begin ok = 1'b1; w = sb1.pop_front(); end
      1: if (sb2.size() > 0) begin ok = 1'b1; w = sb2.pop_front(); end
      default: if (sb3.size() > 0) begin ok = 1'b1; w = sb3.pop_front(); end
    endcase
  endtask

  task automatic mon(input int n, input logic e, input logic [31:0] d);
    logic        ok;
    logic [31:0] w;
    if (e) begin
      pulses[n]++;
      sb_pop(n, ok, w);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL emit_unexpected port=%0d actual=%0h required=none", n + 1, d);
      end else if (d !== w) begin
        errors++;
        $display("FAIL emit_data port=%0d actual=%0h required=%0h", n + 1, d, w);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, en1, data1);
    mon(1, en2, data2);
    mon(2, en3, data3);
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = 4'hF;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic push(input int n, input logic [31:0] w, input logic enq);
    wr(4'(n + 1), w);
    if (enq) begin
      case (n)
        0: sb1.push_back(w);
        1: sb2.push_back(w);
        default: sb3.push_back(w);
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit exp_en [5];
    int rem;
    logic r;
    logic [31:0] exp_cnt;

    tbl[0]  = '{4'd8,  32'd0};
    tbl[1]  = '{4'd9,  32'd0};
    tbl[2]  = '{4'd10, 32'd0};
    tbl[3]  = '{4'd11, 32'd0};
    tbl[4]  = '{4'd12, 32'd0};
    tbl[5]  = '{4'd13, 32'd0};
    tbl[6]  = '{4'd14, 32'd0};
    tbl[7]  = '{4'd3,  32'd252};
    tbl[8]  = '{4'd0,  32'd252};
    tbl[9]  = '{4'd15, 32'd252};
    tbl[10] = '{4'd5,  32'd252};
    tbl[11] = '{4'd7,  32'd252};

    pulses = '{0, 0, 0};
    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    byteenable = 4'h0; address = '0; writedata = '0;
    rdy1 = 1'b0; rdy2 = 1'b0; rdy3 = 1'b0;
    idle(2);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_en", {29'd0, en3, en2, en1}, 32'd0);
    chk("reset_data1", data1, 32'd0);
    chk("reset_data3", data3, 32'd0);
    reset_n = 1'b1;
    idle(1);
    chk("idle_bus_251", readdata, 32'd251);

    for (int i = 0; i < 12; i++) rd_chk($sformatf("reg_tbl_%0d", i), tbl[i].addr, tbl[i].exp);

    // Three words through port 1, emitted on consecutive cycles.
    push(0, 32'h11, 1'b1);
    push(0, 32'h22, 1'b1);
    push(0, 32'h33, 1'b1);
    rd_chk("fill1_3", 4'd8, 32'd3);
    rdy1 = 1'b1;
    wr(4'd4, 32'h1);
    exp_en = '{0, 1, 1, 1, 0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("en1_seq_%0d", k), {31'd0, en1}, {31'd0, exp_en[k]});
    end
    rd_chk("sent1_3", 4'd11, 32'd3);
    rd_chk("status_run", 4'd14, 32'd1);
    wr(4'd4, 32'h4);
    rd_chk("status_idle", 4'd14, 32'd0);

    // Overflow on port 2, then flush.
    for (int k = 0; k < int'(DEPTH) + 2; k++) push(1, 32'h200 + k, 1'b0);
    rd_chk("fill2_full", 4'd9, DEPTH);
    rd_chk("status_ovf2", 4'd14, 32'h20);
    wr(4'd4, 32'h2);
    idle(1);
    rd_chk("fill2_flushed", 4'd9, 32'd0);
    rd_chk("status_flushed", 4'd14, 32'd0);
    rd_chk("sent1_flushed", 4'd11, 32'd0);

    // Port 3 with rdy3 alternating.
    for (int k = 0; k < 4; k++) push(2, 32'hC1 + k, 1'b1);
    wr(4'd4, 32'h1);
    rem = 4;
    for (int k = 0; k < 8; k++) begin
      r = (k % 2 == 0);
      rdy3 = r;
      idle(1);
      chk($sformatf("en3_toggle_%0d", k), {31'd0, en3}, {31'd0, r && rem > 0});
      if (r && rem > 0) rem--;
    end
    rdy3 = 1'b0;
    rd_chk("sent3_4", 4'd12 + 4'd1, 32'd4);
    rd_chk("fill3_0", 4'd10, 32'd0);
    wr(4'd4, 32'h4);

    // Zero word handling on port 1.
    pulses[0] = 0;
    push(0, 32'hA, 1'b1);
`ifdef INGRESS_ZERO_SKIP_EN
    push(0, 32'h0, 1'b0);
    exp_cnt = 32'd2;
`else
    push(0, 32'h0, 1'b1);
    exp_cnt = 32'd3;
`endif
    push(0, 32'hB, 1'b1);
    wr(4'd4, 32'h1);
    idle(6);
    chk("zero_pulses", pulses[0], exp_cnt);
    rd_chk("zero_sent1", 4'd11, exp_cnt);
    rd_chk("zero_fill1", 4'd8, 32'd0);

    // Reset with words pending in RUN.
    rdy2 = 1'b0;
    for (int k = 0; k < 4; k++) push(1, 32'hE0 + k, 1'b0);
    idle(2);
    reset_n = 1'b0;
    idle(1);
    chk("rst_en", {29'd0, en3, en2, en1}, 32'd0);
    chk("rst_data1", data1, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    rdy1 = 1'b1; rdy2 = 1'b1; rdy3 = 1'b1;
    idle(4);
    rd_chk("rst_fill1", 4'd8, 32'd0);
    rd_chk("rst_fill2", 4'd9, 32'd0);
    rd_chk("rst_fill3", 4'd10, 32'd0);
    rd_chk("rst_status", 4'd14, 32'd0);
    rd_chk("addr3_252", 4'd3, 32'd252);
    idle(1);
    chk("idle_251", readdata, 32'd251);

    // Ignored writes: partial byte enables and write+read together.
    chipselect = 1'b1; write = 1'b1; address = 4'd1; writedata = 32'h55; byteenable = 4'h3;
    idle(1);
    chipselect = 1'b0; write = 1'b0;
    rd_chk("be_partial_fill1", 4'd8, 32'd0);
    chipselect = 1'b1; write = 1'b1; read = 1'b1; address = 4'd1; byteenable = 4'hF;
    idle(1);
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    chk("rw_readdata", readdata, 32'd252);
    rd_chk("rw_fill1", 4'd8, 32'd0);
    idle(3);

    chk("sb1_drained", sb1.size(), 32'd0);
    chk("sb3_drained", sb3.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
